// File: rtl/clkdiv_if.sv
// clkdiv_if: control and status bundle for clkdiv_bank; sync_i exists only with CLKDIV_SYNC_EN.
interface clkdiv_if #(
  parameter int N   = 4,
  parameter int CW  = 7,
  parameter int CHW = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]   en;
  logic           wr_en;
  logic [CHW-1:0] wr_ch;
  logic [CW-1:0]  wr_data;
`ifdef CLKDIV_SYNC_EN
  logic           sync_i;
`endif
  logic [N-1:0]   CLKOUT;
  logic [N-1:0]   tick;
  logic [N-1:0]   pend;
`ifdef CLKDIV_SYNC_EN
  modport master (output en, wr_en, wr_ch, wr_data, sync_i, input CLKOUT, tick, pend);
  modport slave  (input en, wr_en, wr_ch, wr_data, sync_i, output CLKOUT, tick, pend);
`else
  modport master (output en, wr_en, wr_ch, wr_data, input CLKOUT, tick, pend);
  modport slave  (input en, wr_en, wr_ch, wr_data, output CLKOUT, tick, pend);
`endif
endinterface

// File: rtl/clkdiv_bank.sv
// clkdiv_bank: N independent even-ratio clock dividers with boundary-committed terminal counts.
// Optional phase-align strobe sync_i is built when CLKDIV_SYNC_EN is defined.
module clkdiv_bank #(
  parameter int N          = 4,
  parameter int CW         = 7,
  parameter int DEFAULT_TC = 81
) (
  input logic     CLKIN,
  input logic     aclr_i,
  clkdiv_if.slave bus
);
  localparam int CHW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] TC0 = CW'(DEFAULT_TC);
  for (genvar c = 0; c < N; c++) begin : g_ch
    logic [CW-1:0] cnt, term, shadow;
    logic clk_q, tick_q, pend_q;
    logic hit, bnd, sy;
    assign hit = bus.wr_en && (bus.wr_ch == CHW'(c));
    assign bnd = cnt == term;
`ifdef CLKDIV_SYNC_EN
    assign sy = bus.sync_i;
`else
    assign sy = 1'b0;
`endif
    // term only changes at a half-period boundary (or sync) so no runt half-periods occur
    always_ff @(posedge CLKIN or posedge aclr_i) begin
      if (aclr_i) begin
        cnt    <= '0;
        term   <= TC0;
        shadow <= TC0;
        pend_q <= 1'b0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else if (!bus.en[c]) begin
        cnt    <= '0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
        if (hit) begin
          term   <= bus.wr_data;
          shadow <= bus.wr_data;
          pend_q <= 1'b0;
        end
      end else begin
        if (sy) begin
          cnt    <= '0;
          clk_q  <= 1'b0;
          tick_q <= 1'b0;
        end else if (bnd) begin
          cnt    <= '0;
          clk_q  <= ~clk_q;
          tick_q <= 1'b1;
        end else begin
          cnt    <= cnt + 1'b1;
          tick_q <= 1'b0;
        end
        if ((sy || bnd) && pend_q) term <= shadow;
        if (hit) begin
          shadow <= bus.wr_data;
          pend_q <= 1'b1;
        end else if (sy || bnd) begin
          pend_q <= 1'b0;
        end
      end
    end
    assign bus.CLKOUT[c] = clk_q;
    assign bus.tick[c]   = tick_q;
    assign bus.pend[c]   = pend_q;
  end
endmodule

// File: tb/tb_clkdiv_bank.sv
// tb_clkdiv_bank: directed self-checking bench for clkdiv_bank (3 channels so wr_ch=3 is out of range).
module tb_clkdiv_bank;
  localparam int N = 3;
  localparam int CW = 7;
  logic clk = 1'b0;
  logic aclr = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  clkdiv_if #(.N(N), .CW(CW)) bus ();
  clkdiv_bank #(.N(N), .CW(CW), .DEFAULT_TC(81)) dut (.CLKIN(clk), .aclr_i(aclr), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    bus.en = '0;
    bus.wr_en = 1'b0;
    aclr = 1'b1;
    #2;
    aclr = 1'b0;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [CW-1:0] d);
    bus.wr_en = 1'b1;
    bus.wr_ch = ch;
    bus.wr_data = d;
    step(1);
    bus.wr_en = 1'b0;
  endtask

  task automatic test_reset;
    step(2);
    n_cmp++; if (bus.CLKOUT !== 3'b000) begin n_bad++; $display("FAIL reset_clkout: got %b expected 000", bus.CLKOUT); end
    n_cmp++; if (bus.tick !== 3'b000) begin n_bad++; $display("FAIL reset_tick: got %b expected 000", bus.tick); end
    n_cmp++; if (bus.pend !== 3'b000) begin n_bad++; $display("FAIL reset_pend: got %b expected 000", bus.pend); end
  endtask

  task automatic test_default;
    do_reset();
    bus.en = 3'b001;
    step(81);
    n_cmp++; if (bus.CLKOUT !== 3'b000) begin n_bad++; $display("FAIL def_e81: got %b expected 000", bus.CLKOUT); end
    step(1);
    n_cmp++; if (bus.CLKOUT !== 3'b001) begin n_bad++; $display("FAIL def_e82_clk: got %b expected 001", bus.CLKOUT); end
    n_cmp++; if (bus.tick !== 3'b001) begin n_bad++; $display("FAIL def_e82_tick: got %b expected 001", bus.tick); end
    step(1);
    n_cmp++; if (bus.tick !== 3'b000) begin n_bad++; $display("FAIL def_e83_tick: got %b expected 000", bus.tick); end
    step(80);
    n_cmp++; if (bus.CLKOUT !== 3'b001) begin n_bad++; $display("FAIL def_e163: got %b expected 001", bus.CLKOUT); end
    step(1);
    n_cmp++; if (bus.CLKOUT !== 3'b000) begin n_bad++; $display("FAIL def_e164_clk: got %b expected 000", bus.CLKOUT); end
    n_cmp++; if (bus.tick !== 3'b001) begin n_bad++; $display("FAIL def_e164_tick: got %b expected 001", bus.tick); end
  endtask

  task automatic test_write;
    do_reset();
    bus.en = 3'b010;
    step(10);
    wr(2'd1, 7'd3);
    n_cmp++; if (bus.pend !== 3'b010) begin n_bad++; $display("FAIL wr_pend_set: got %b expected 010", bus.pend); end
    step(70);
    n_cmp++; if (bus.pend !== 3'b010) begin n_bad++; $display("FAIL wr_pend_hold: got %b expected 010", bus.pend); end
    n_cmp++; if (bus.CLKOUT !== 3'b000) begin n_bad++; $display("FAIL wr_e81: got %b expected 000", bus.CLKOUT); end
    step(1);
    n_cmp++; if (bus.CLKOUT !== 3'b010 || bus.tick !== 3'b010) begin n_bad++; $display("FAIL wr_e82: got clk %b tick %b expected 010/010", bus.CLKOUT, bus.tick); end
    n_cmp++; if (bus.pend !== 3'b000) begin n_bad++; $display("FAIL wr_commit: got %b expected 000", bus.pend); end
    for (int i = 1; i <= 16; i++) begin
      step(1);
      n_cmp++; if (bus.CLKOUT[1] !== ((i / 4) % 2 == 0) || bus.tick[1] !== (i % 4 == 0)) begin
        n_bad++; $display("FAIL wr_div8 i=%0d: got clk %b tick %b expected %b/%b", i, bus.CLKOUT[1], bus.tick[1], (i / 4) % 2 == 0, i % 4 == 0);
      end
    end
  endtask

  task automatic test_back_to_back;
    wr(2'd1, 7'd5);
    n_cmp++; if (bus.pend[1] !== 1'b1) begin n_bad++; $display("FAIL b2b_pend5: got %b expected 1", bus.pend[1]); end
    step(2);
    wr(2'd1, 7'd9);
    n_cmp++; if (bus.pend[1] !== 1'b1 || bus.tick[1] !== 1'b1) begin n_bad++; $display("FAIL b2b_bnd: got pend %b tick %b expected 1/1", bus.pend[1], bus.tick[1]); end
    for (int j = 1; j <= 6; j++) begin
      step(1);
      n_cmp++; if (bus.tick[1] !== (j == 6) || bus.pend[1] !== (j < 6)) begin
        n_bad++; $display("FAIL b2b_half6 j=%0d: got tick %b pend %b expected %b/%b", j, bus.tick[1], bus.pend[1], j == 6, j < 6);
      end
    end
    for (int j = 1; j <= 10; j++) begin
      step(1);
      n_cmp++; if (bus.tick[1] !== (j == 10) || bus.pend[1] !== 1'b0) begin
        n_bad++; $display("FAIL b2b_half10 j=%0d: got tick %b pend %b expected %b/0", j, bus.tick[1], bus.pend[1], j == 10);
      end
    end
  endtask

  task automatic test_tc_zero;
    do_reset();
    wr(2'd2, 7'd0);
    wr(2'd3, 7'd0);
    n_cmp++; if (bus.pend !== 3'b000) begin n_bad++; $display("FAIL tc0_pend: got %b expected 000", bus.pend); end
    bus.en = 3'b111;
    for (int i = 1; i <= 6; i++) begin
      step(1);
      n_cmp++; if (bus.CLKOUT !== {i[0], 2'b00} || bus.tick !== 3'b100) begin
        n_bad++; $display("FAIL tc0 i=%0d: got clk %b tick %b expected %b/100", i, bus.CLKOUT, bus.tick, {i[0], 2'b00});
      end
    end
  endtask

  task automatic test_async_clear;
    wr(2'd0, 7'd7);
    n_cmp++; if (bus.pend !== 3'b001) begin n_bad++; $display("FAIL clr_pend_pre: got %b expected 001", bus.pend); end
    #2 aclr = 1'b1;
    #1;
    n_cmp++; if (bus.CLKOUT !== 3'b000 || bus.tick !== 3'b000 || bus.pend !== 3'b000) begin
      n_bad++; $display("FAIL clr_now: got clk %b tick %b pend %b expected 000", bus.CLKOUT, bus.tick, bus.pend);
    end
    #1 aclr = 1'b0;
    bus.en = 3'b101;
    step(8);
    n_cmp++; if (bus.CLKOUT !== 3'b000) begin n_bad++; $display("FAIL clr_e8: got %b expected 000", bus.CLKOUT); end
    step(73);
    n_cmp++; if (bus.CLKOUT !== 3'b000) begin n_bad++; $display("FAIL clr_e81: got %b expected 000", bus.CLKOUT); end
    step(1);
    n_cmp++; if (bus.CLKOUT !== 3'b101) begin n_bad++; $display("FAIL clr_e82: got %b expected 101", bus.CLKOUT); end
  endtask

`ifdef CLKDIV_SYNC_EN
  task automatic test_sync;
    do_reset();
    wr(2'd0, 7'd3);
    wr(2'd1, 7'd5);
    bus.en = 3'b011;
    step(7);
    bus.sync_i = 1'b1;
    step(1);
    bus.sync_i = 1'b0;
    n_cmp++; if (bus.CLKOUT !== 3'b000 || bus.tick !== 3'b000) begin n_bad++; $display("FAIL sync_edge: got clk %b tick %b expected 000/000", bus.CLKOUT, bus.tick); end
    for (int k = 1; k <= 6; k++) begin
      step(1);
      n_cmp++; if (bus.CLKOUT[0] !== (k >= 4) || bus.CLKOUT[1] !== (k >= 6)) begin
        n_bad++; $display("FAIL sync_k%0d: got %b%b expected %b%b", k, bus.CLKOUT[1], bus.CLKOUT[0], k >= 6, k >= 4);
      end
    end
  endtask
`endif

  initial begin
    bus.en = '0;
    bus.wr_en = 1'b0;
    bus.wr_ch = '0;
    bus.wr_data = '0;
`ifdef CLKDIV_SYNC_EN
    bus.sync_i = 1'b0;
`endif
    test_reset();
    test_default();
    test_write();
    test_back_to_back();
    test_tc_zero();
    test_async_clear();
`ifdef CLKDIV_SYNC_EN
    test_sync();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
